// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/2-write register file.
// No logic; no latency or backpressure of its own.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int REGFILE_WIDTH = 16;
  localparam int REGFILE_DEPTH = 16;

  function automatic bit depth_ok(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_2r2w_if.sv
// Operand-bus bundle for regfile_2r2w: clear/ready, two read ports, two write ports.
// Reads return one cycle after the address; no backpressure beyond the ready level.
interface regfile_2r2w_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clear;
  logic              ready;
  logic [ADDR_W-1:0] rd_num1;
  logic [ADDR_W-1:0] rd_num2;
  logic [WIDTH-1:0]  bus_out1;
  logic [WIDTH-1:0]  bus_out2;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_num1;
  logic [WIDTH-1:0]  wr_data1;
  logic              wr_en2;
  logic [ADDR_W-1:0] wr_num2;
  logic [WIDTH-1:0]  wr_data2;

  modport master (
    output clear, rd_num1, rd_num2,
    output wr_en1, wr_num1, wr_data1, wr_en2, wr_num2, wr_data2,
    input  ready, bus_out1, bus_out2
  );

  modport slave (
    input  clear, rd_num1, rd_num2,
    input  wr_en1, wr_num1, wr_data1, wr_en2, wr_num2, wr_data2,
    output ready, bus_out1, bus_out2
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port with write-port-1 > write-port-2 > array bypass priority.
// Latency 1 cycle; never stalls. REGFILE_ZERO_REG_EN forces address 0 to read zero.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REGFILE_WIDTH,
  parameter int ADDR_W = $clog2(REGFILE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              zero,
  input  logic [ADDR_W-1:0] rd_num,
  input  logic [WIDTH-1:0]  ent_dat,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wr_num1,
  input  logic [WIDTH-1:0]  wr_data1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wr_num2,
  input  logic [WIDTH-1:0]  wr_data2,
  output logic [WIDTH-1:0]  bus_out
);

  logic [WIDTH-1:0] nxt_dat;

  always_comb begin
    nxt_dat = ent_dat;
    if (we2 && (wr_num2 == rd_num)) nxt_dat = wr_data2;
    // Port 1 is applied last so it overrides port 2 on an address tie.
    if (we1 && (wr_num1 == rd_num)) nxt_dat = wr_data1;
`ifdef REGFILE_ZERO_REG_EN
    if (rd_num == '0) nxt_dat = '0;
`endif
    if (zero) nxt_dat = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_out <= '0;
    else     bus_out <= nxt_dat;
  end

endmodule

// File: rtl/regfile_2r2w.sv
// DEPTH x WIDTH register file, 2 registered reads (1 cycle, bypassed), 2 writes, clear sequencer.
// No backpressure; ready is low for DEPTH cycles while clearing. Option: REGFILE_ZERO_REG_EN.
module regfile_2r2w
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH
) (
  input logic           clk,
  input logic           rst,
  regfile_2r2w_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("regfile_2r2w: DEPTH must be a power of two >= 2");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, idx_nxt;
  logic              clr_we;
  logic              we1, we2;
  logic              out_zero;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  ent1, ent2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    if (state == CLEAR) begin
      clr_we = 1'b1;
      if (bus.clear) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
    end else if (bus.clear) begin
      state_nxt = CLEAR;
      idx_nxt   = '0;
    end
  end

  assign bus.ready = (state == RUN);

  // A clear request discards writes presented in the same cycle.
`ifdef REGFILE_ZERO_REG_EN
  assign we1 = bus.wr_en1 && (state == RUN) && !bus.clear && (bus.wr_num1 != '0);
  assign we2 = bus.wr_en2 && (state == RUN) && !bus.clear && (bus.wr_num2 != '0);
`else
  assign we1 = bus.wr_en1 && (state == RUN) && !bus.clear;
  assign we2 = bus.wr_en2 && (state == RUN) && !bus.clear;
`endif

  // Storage carries no reset so it can map onto block RAM; the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we2) mem[bus.wr_num2] <= bus.wr_data2;
      if (we1) mem[bus.wr_num1] <= bus.wr_data1;
    end
  end

  assign ent1     = mem[bus.rd_num1];
  assign ent2     = mem[bus.rd_num2];
  assign out_zero = (state != RUN) || bus.clear;

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rd1 (
    .clk      (clk),
    .rst      (rst),
    .zero     (out_zero),
    .rd_num   (bus.rd_num1),
    .ent_dat  (ent1),
    .we1      (we1),
    .wr_num1  (bus.wr_num1),
    .wr_data1 (bus.wr_data1),
    .we2      (we2),
    .wr_num2  (bus.wr_num2),
    .wr_data2 (bus.wr_data2),
    .bus_out  (bus.bus_out1)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rd2 (
    .clk      (clk),
    .rst      (rst),
    .zero     (out_zero),
    .rd_num   (bus.rd_num2),
    .ent_dat  (ent2),
    .we1      (we1),
    .wr_num1  (bus.wr_num1),
    .wr_data1 (bus.wr_data1),
    .we2      (we2),
    .wr_num2  (bus.wr_num2),
    .wr_data2 (bus.wr_data2),
    .bus_out  (bus.bus_out2)
  );

endmodule

// File: tb/tb_regfile_2r2w.sv
// Directed bench for regfile_2r2w at WIDTH=16, DEPTH=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_regfile_2r2w;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   n;

  always #5 clk = ~clk;

  regfile_2r2w_if #(.WIDTH(16), .DEPTH(16)) bus ();

  regfile_2r2w #(.WIDTH(16), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.rd_num1 = '0;  bus.rd_num2 = '0;
    bus.wr_en1 = 1'b0; bus.wr_num1 = '0; bus.wr_data1 = '0;
    bus.wr_en2 = 1'b0; bus.wr_num2 = '0; bus.wr_data2 = '0;
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_out1", {16'd0, bus.bus_out1}, 32'd0);
    check("rst_out2", {16'd0, bus.bus_out2}, 32'd0);

    repeat (3) tick();
    rst = 1'b0;
    wait_ready(n);
    check("init_seq_len", n, 32'd16);

    for (int a = 0; a < 16; a++) begin
      bus.rd_num1 = 4'(a);
      bus.rd_num2 = 4'(15 - a);
      tick();
      check("init_zero_p1", {16'd0, bus.bus_out1}, 32'd0);
      check("init_zero_p2", {16'd0, bus.bus_out2}, 32'd0);
    end

    // Dual write to different addresses.
    bus.wr_en1 = 1'b1; bus.wr_num1 = 4'd3; bus.wr_data1 = 16'hBEEF;
    bus.wr_en2 = 1'b1; bus.wr_num2 = 4'd7; bus.wr_data2 = 16'h1234;
    tick();
    bus.wr_en1 = 1'b0; bus.wr_en2 = 1'b0;
    bus.rd_num1 = 4'd3; bus.rd_num2 = 4'd7;
    tick();
    check("dual_p1", {16'd0, bus.bus_out1}, 32'h0000BEEF);
    check("dual_p2", {16'd0, bus.bus_out2}, 32'h00001234);

    // Port-2 write bypassed to both read ports.
    bus.wr_en2 = 1'b1; bus.wr_num2 = 4'd9; bus.wr_data2 = 16'h4321;
    bus.rd_num1 = 4'd9; bus.rd_num2 = 4'd9;
    tick();
    bus.wr_en2 = 1'b0;
    check("byp_w2_p1", {16'd0, bus.bus_out1}, 32'h00004321);
    check("byp_w2_p2", {16'd0, bus.bus_out2}, 32'h00004321);
    tick();
    check("byp_w2_mem", {16'd0, bus.bus_out1}, 32'h00004321);

    // Same-address conflict: port 1 wins in storage and in the bypass.
    bus.wr_en1 = 1'b1; bus.wr_num1 = 4'd5; bus.wr_data1 = 16'hAAAA;
    bus.wr_en2 = 1'b1; bus.wr_num2 = 4'd5; bus.wr_data2 = 16'h5555;
    bus.rd_num1 = 4'd5; bus.rd_num2 = 4'd5;
    tick();
    bus.wr_en1 = 1'b0; bus.wr_en2 = 1'b0;
    check("conf_byp_p1", {16'd0, bus.bus_out1}, 32'h0000AAAA);
    check("conf_byp_p2", {16'd0, bus.bus_out2}, 32'h0000AAAA);
    tick();
    check("conf_mem", {16'd0, bus.bus_out1}, 32'h0000AAAA);

    // Async reset while running.
    bus.rd_num1 = 4'd3;
    tick();
    check("run_pre_rst", {16'd0, bus.bus_out1}, 32'h0000BEEF);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, bus.ready}, 32'd0);
    check("arst_out1", {16'd0, bus.bus_out1}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n);
    check("arst_seq_len", n, 32'd16);
    tick();
    check("arst_cleared", {16'd0, bus.bus_out1}, 32'd0);

    // Fill every entry with 0xFFFF.
    for (int a = 0; a < 16; a += 2) begin
      bus.wr_en1 = 1'b1; bus.wr_num1 = 4'(a);     bus.wr_data1 = 16'hFFFF;
      bus.wr_en2 = 1'b1; bus.wr_num2 = 4'(a + 1); bus.wr_data2 = 16'hFFFF;
      tick();
    end
    bus.wr_en1 = 1'b0; bus.wr_en2 = 1'b0;
    bus.rd_num1 = 4'd2; bus.rd_num2 = 4'd15;
    tick();
    check("fill_e2", {16'd0, bus.bus_out1}, 32'h0000FFFF);
    check("fill_e15", {16'd0, bus.bus_out2}, 32'h0000FFFF);

    // Clear pulse with a write in the same cycle; a write during CLEAR is ignored.
    bus.clear = 1'b1;
    bus.wr_en1 = 1'b1; bus.wr_num1 = 4'd2; bus.wr_data1 = 16'h0102;
    tick();
    bus.clear = 1'b0; bus.wr_en1 = 1'b0;
    check("clr_ready", {31'd0, bus.ready}, 32'd0);
    check("clr_out1", {16'd0, bus.bus_out1}, 32'd0);
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      if (n == 10) begin
        bus.wr_en1 = 1'b1; bus.wr_num1 = 4'd4; bus.wr_data1 = 16'h4444;
      end else begin
        bus.wr_en1 = 1'b0;
      end
      tick();
      n++;
      if (n == 5) check("clr_hold_out2", {16'd0, bus.bus_out2}, 32'd0);
    end
    bus.wr_en1 = 1'b0;
    check("clr_seq_len", n, 32'd16);
    bus.rd_num1 = 4'd2; bus.rd_num2 = 4'd4;
    tick();
    check("clr_e2", {16'd0, bus.bus_out1}, 32'd0);
    check("clr_e4_ignored", {16'd0, bus.bus_out2}, 32'd0);
    bus.rd_num2 = 4'd15;
    tick();
    check("clr_e15", {16'd0, bus.bus_out2}, 32'd0);

    // Async reset in the middle of a clear sequence (clr_idx == 9).
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    check("mc_ready", {31'd0, bus.ready}, 32'd0);
    check("mc_out1", {16'd0, bus.bus_out1}, 32'd0);
    check("mc_out2", {16'd0, bus.bus_out2}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n);
    check("mc_seq_len", n, 32'd16);

    // Write to entry 0 with a same-cycle read of entry 0.
    bus.wr_en1 = 1'b1; bus.wr_num1 = 4'd0; bus.wr_data1 = 16'h7777;
    bus.rd_num1 = 4'd0;
    tick();
    bus.wr_en1 = 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    check("zr_bypass", {16'd0, bus.bus_out1}, 32'd0);
    tick();
    check("zr_mem", {16'd0, bus.bus_out1}, 32'd0);
`else
    check("zr_bypass", {16'd0, bus.bus_out1}, 32'h00007777);
    tick();
    check("zr_mem", {16'd0, bus.bus_out1}, 32'h00007777);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
